// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, sequencer state encoding and the
// condition-code flag bundle used by the multi-cycle ALU operations.
package alu_pkg;

    localparam int DATA_W  = 64;
    localparam int CHUNK_W = 8;
    localparam int NCHUNK  = DATA_W / CHUNK_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_seq_state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic o;
    } alu_flags_t;

endpackage

// File: rtl/add64_seq_add_chunk.sv
// W-bit ripple-carry adder built from full-adder cells; the sequential adder
// reuses one instance for every slice of the operands.
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[W];

endmodule

// File: rtl/add64_seq.sv
// Multi-cycle adder: one CHUNK_W slice per clock with a registered ripple carry.
// Define ADD64_SEQ_SUB_EN to add the 'sub' port (in1 - in2 via inverted addend).
module add64_seq #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
`ifdef ADD64_SEQ_SUB_EN
    input  logic              sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              z_add_flag,
    output logic              c_add_flag,
    output logic              o_add_flag,
    output logic              busy
);

    import alu_pkg::*;

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    alu_seq_state_t    state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d, sub_in;
    alu_flags_t        flags_q, flags_d;
    logic [CHUNK_W-1:0] ch_a, ch_b, ch_sum;
    logic              ch_cout;

`ifdef ADD64_SEQ_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign ch_a = a_q[int'(cnt_q) * CHUNK_W +: CHUNK_W];
    assign ch_b = b_q[int'(cnt_q) * CHUNK_W +: CHUNK_W];

    add_chunk #(.W(CHUNK_W)) u_chunk (
        .a_i    (ch_a),
        .b_i    (ch_b),
        .cin_i  (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is in1 + ~in2 + 1: invert at latch, seed carry.
                    a_d     = in1;
                    b_d     = sub_in ? ~in2 : in2;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                    carry_d = sub_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q) * CHUNK_W +: CHUNK_W] = ch_sum;
                carry_d = ch_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    flags_d.z = (sum_d == '0);
                    flags_d.c = ch_cout ^ sub_q;
                    // b_q is already inverted for sub, so one rule covers both.
                    flags_d.o = (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out        = sum_q;
    assign z_add_flag = flags_q.z;
    assign c_add_flag = flags_q.c;
    assign o_add_flag = flags_q.o;

endmodule

// File: tb/tb_add64_seq.sv
// Directed self-checking bench for add64_seq (subtract cases need ADD64_SEQ_SUB_EN).
module tb_add64_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in1 = '0;
    logic [63:0] in2 = '0;
`ifdef ADD64_SEQ_SUB_EN
    logic        sub_r = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out;
    logic        z_add_flag, c_add_flag, o_add_flag, busy;

    int n_tests = 0;
    int n_fail  = 0;

    add64_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
`ifdef ADD64_SEQ_SUB_EN
        .sub        (sub_r),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .z_add_flag (z_add_flag),
        .c_add_flag (c_add_flag),
        .o_add_flag (o_add_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Present one operand pair, then wait (bounded) for out_valid; lat = -1 on timeout.
    task automatic do_op(input logic [63:0] x, input logic [63:0] y, output int lat);
        in1 = x;
        in2 = y;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hs got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        end
        n_tests++;
        if (out !== 64'h0 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_data got out=%h flags=%b want 0/000", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_simple_add();
        int lat;
        do_op(64'h5, 64'h3, lat);
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL simple_latency got %0d want 8", lat);
        end
        n_tests++;
        if (out !== 64'h8 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b000) begin
            n_fail++;
            $display("FAIL simple_add got out=%h flags=%b want 8/000", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 64'h8) begin
            n_fail++;
            $display("FAIL simple_release got vld=%b rdy=%b out=%h want 0/1/8", out_valid, in_ready, out);
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
        n_tests++;
        if (lat !== 8 || out !== 64'h0 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b110) begin
            n_fail++;
            $display("FAIL wrap_all_ones got lat=%0d out=%h zco=%b want 8/0/110", lat, out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, lat);
        n_tests++;
        if (out !== 64'h8000_0000_0000_0000 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_pos_ovf got out=%h zco=%b want 8000000000000000/001", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
        n_tests++;
        if (out !== 64'h0 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b111) begin
            n_fail++;
            $display("FAIL wrap_neg_ovf got out=%h zco=%b want 0/111", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
    endtask

    task automatic test_cross_chunk();
        int lat;
        do_op(64'h00FF, 64'h0001, lat);
        n_tests++;
        if (out !== 64'h0100 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b000) begin
            n_fail++;
            $display("FAIL cross_chunk01 got out=%h zco=%b want 0100/000", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        do_op(64'h00FF_FFFF_FFFF_FFFF, 64'h1, lat);
        n_tests++;
        if (out !== 64'h0100_0000_0000_0000 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b000) begin
            n_fail++;
            $display("FAIL cross_chunk_all got out=%h zco=%b want 0100000000000000/000", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, lat);
        for (int i = 0; i < 5; i++) begin
            in1 = 64'hFFFF_FFFF_FFFF_FFFF;
            in2 = 64'hFFFF_FFFF_FFFF_FFFF;
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if (out !== 64'h1234_5678_9ABC_DF00 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got out=%h zco=%b want 123456789abcdf00/000", i, out, {z_add_flag, c_add_flag, o_add_flag});
            end
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hs[%0d] got vld=%b rdy=%b busy=%b want 1/0/1", i, out_valid, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        release_result();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        do_op(64'h2, 64'h2, lat);
        n_tests++;
        if (lat !== 8 || out !== 64'h4) begin
            n_fail++;
            $display("FAIL bp_next_op got lat=%0d out=%h want 8/4", lat, out);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int k, c0, c1;
        in1 = 64'h10;
        in2 = 64'h20;
        in_valid = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        c0 = k;
        @(posedge clk); #1;
        k++;
        while (out_valid !== 1'b1 && k < 80) begin
            @(posedge clk); #1;
            k++;
        end
        c1 = k;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (c0 !== 9 || c1 - c0 !== 10) begin
            n_fail++;
            $display("FAIL b2b_spacing got first=%0d period=%0d want 9/10", c0, c1 - c0);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out !== 64'h30) begin
            n_fail++;
            $display("FAIL b2b_result got vld=%b out=%h want 1/30", out_valid, out);
        end
        release_result();
    endtask

`ifdef ADD64_SEQ_SUB_EN
    task automatic test_sub();
        int lat;
        sub_r = 1'b1;
        do_op(64'h3, 64'h5, lat);
        n_tests++;
        if (lat !== 8 || out !== 64'hFFFF_FFFF_FFFF_FFFE || {z_add_flag, c_add_flag, o_add_flag} !== 3'b010) begin
            n_fail++;
            $display("FAIL sub_borrow got lat=%0d out=%h zco=%b want 8/fffffffffffffffe/010", lat, out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        do_op(64'h8000_0000_0000_0000, 64'h1, lat);
        n_tests++;
        if (out !== 64'h7FFF_FFFF_FFFF_FFFF || {z_add_flag, c_add_flag, o_add_flag} !== 3'b001) begin
            n_fail++;
            $display("FAIL sub_ovf got out=%h zco=%b want 7fffffffffffffff/001", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, lat);
        n_tests++;
        if (out !== 64'h0 || {z_add_flag, c_add_flag, o_add_flag} !== 3'b100) begin
            n_fail++;
            $display("FAIL sub_equal got out=%h zco=%b want 0/100", out, {z_add_flag, c_add_flag, o_add_flag});
        end
        release_result();
        sub_r = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        bit seen_valid;
        in1 = 64'h1111_1111_1111_1111;
        in2 = 64'h1111_1111_1111_1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_running got busy=%b rdy=%b want 1/0", busy, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out !== 64'h0 ||
            {z_add_flag, c_add_flag, o_add_flag} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_values got rdy/vld/busy=%b out=%h zco=%b want 100/0/000",
                     {in_ready, out_valid, busy}, out, {z_add_flag, c_add_flag, o_add_flag});
        end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        out_ready = 1'b0;
        n_tests++;
        if (seen_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_lost got seen_valid=%b rdy=%b want 0/1", seen_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_simple_add();
        test_wrap();
        test_cross_chunk();
        test_backpressure();
        test_back_to_back();
`ifdef ADD64_SEQ_SUB_EN
        test_sub();
`endif
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
